// File: rtl/exp_horner_core.sv
// ----------------------------------------------------------------------------
// exp_horner_core
//
// Iterative e^(+/-x) evaluator in signed fixed point (Q(WIDTH-FRAC).FRAC).
// It evaluates an N_TERMS Taylor series in Horner form:
//   acc = 1 + (s*acc)/k   for k = N_TERMS-1 down to 1, with s = +/-x.
// Each iteration needs two multiplies: s*acc, then the result times 1/k.
// Only one transaction is in flight at a time.
//
// Optional build macro:
//   EXP_SAT_EN - saturate every truncated product, the ONE+ add and the
//                negation of x. A negative final result clamps to 0, and any
//                clamp raises the sticky ovf flag. When the macro is
//                undefined, all arithmetic wraps and ovf is tied low.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous, active-high reset
//   in_valid  in   x / neg_mode valid
//   in_ready  out  block can accept (idle only)
//   x         in   argument, signed QFRAC
//   neg_mode  in   1: e^(-x), 0: e^(x)
//   out_valid out  y valid, held until out_ready
//   out_ready in   consumer accepts y
//   y         out  result, signed QFRAC
//   ovf       out  clamp seen during this transaction (EXP_SAT_EN only)
// ----------------------------------------------------------------------------
module exp_horner_core #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned FRAC    = 16,
    parameter int unsigned N_TERMS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic             neg_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             ovf
);

    localparam int unsigned    PW      = 2 * WIDTH;
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1) << FRAC;
    localparam logic [3:0]     K_START = 4'(N_TERMS - 1);
`ifdef EXP_SAT_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    // Reciprocal table: each 1/k is rounded to nearest in QFRAC. Entry 0 is never used.
    typedef logic [15:0][WIDTH-1:0] inv_tab_t;

    function automatic inv_tab_t build_inv();
        inv_tab_t tab;
        tab = '0;
        for (int unsigned k = 1; k < 16; k++) begin
            tab[k] = (ONE + WIDTH'(k / 2)) / WIDTH'(k);
        end
        return tab;
    endfunction

    localparam inv_tab_t INV = build_inv();

`ifdef EXP_SAT_EN
    // After the >>>FRAC, the product must fit in WIDTH signed bits.
    // That holds when every bit from WIDTH+FRAC-1 upward is a sign copy.
    function automatic logic prod_fits(input logic [PW-1:0] p);
        return (p[PW-1:WIDTH+FRAC-1] == '0) || (&p[PW-1:WIDTH+FRAC-1]);
    endfunction
`endif

    // Floor shift by FRAC, keeping WIDTH bits (the top bits wrap away).
    function automatic logic [WIDTH-1:0] trunc_prod(input logic [PW-1:0] p);
        logic [WIDTH-1:0] r;
        r = p[WIDTH+FRAC-1:FRAC];
`ifdef EXP_SAT_EN
        if (!prod_fits(p)) begin
            r = p[PW-1] ? MIN_NEG : MAX_POS;
        end
`endif
        return r;
    endfunction

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [3:0]       k_q, k_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] s_in;
    logic [PW-1:0]    p1, p2;
    logic [WIDTH-1:0] t1, t2, sum_raw, acc_next, y_fin;

    // Datapath: one Horner step per cycle.
    always_comb begin
        s_in = neg_mode ? (WIDTH'(0) - x) : x;
`ifdef EXP_SAT_EN
        if (neg_mode && (x == MIN_NEG)) begin
            s_in = MAX_POS;
        end
`endif
        p1      = {{WIDTH{s_q[WIDTH-1]}}, s_q} * {{WIDTH{acc_q[WIDTH-1]}}, acc_q};
        t1      = trunc_prod(p1);
        p2      = {{WIDTH{t1[WIDTH-1]}}, t1} * {{WIDTH{1'b0}}, INV[k_q]};
        t2      = trunc_prod(p2);
        sum_raw = ONE + t2;
        acc_next = sum_raw;
        y_fin    = acc_next;
`ifdef EXP_SAT_EN
        // ONE is positive, so the add can only overflow upward.
        if (!t2[WIDTH-1] && sum_raw[WIDTH-1]) begin
            acc_next = MAX_POS;
        end
        y_fin = acc_next[WIDTH-1] ? '0 : acc_next;
`endif
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        acc_d       = acc_q;
        k_d         = k_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    s_d     = s_in;
                    acc_d   = ONE;
                    k_d     = K_START;
                    state_d = StIter;
                end
            end
            StIter: begin
                acc_d = acc_next;
                k_d   = k_q - 4'd1;
                if (k_q == 4'd1) begin
                    y_d         = y_fin;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            s_q         <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign y         = y_q;

`ifdef EXP_SAT_EN
    logic ovf_q, ovf_d;
    logic accept_clamp, iter_clamp;

    // ovf is cleared on accept and stays set until the next accept.
    always_comb begin
        accept_clamp = neg_mode && (x == MIN_NEG);
        iter_clamp   = !prod_fits(p1) || !prod_fits(p2)
                       || (!t2[WIDTH-1] && sum_raw[WIDTH-1])
                       || ((k_q == 4'd1) && acc_next[WIDTH-1]);
        ovf_d = ovf_q;
        if ((state_q == StIdle) && in_valid) begin
            ovf_d = accept_clamp;
        end else if (state_q == StIter) begin
            ovf_d = ovf_q | iter_clamp;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_exp_horner_core.sv
module tb_exp_horner_core;

    localparam int     F     = 16;
    localparam longint ONE_L = 64'sd65536;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, neg_mode, out_valid, out_ready, ovf;
    logic [31:0] x, y;
    logic        in_valid2, in_ready2, neg_mode2, out_valid2, out_ready2, ovf2;
    logic [31:0] x2, y2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    exp_horner_core #(.WIDTH(32), .FRAC(16), .N_TERMS(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .neg_mode(neg_mode), .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf)
    );

    exp_horner_core #(.WIDTH(32), .FRAC(16), .N_TERMS(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2), .x(x2),
        .neg_mode(neg_mode2), .out_valid(out_valid2), .out_ready(out_ready2), .y(y2),
        .ovf(ovf2)
    );

    // ---------------- reference model ----------------
    function automatic longint inv_of(input int k);
        return (ONE_L + longint'(k / 2)) / longint'(k);
    endfunction

    // Fit a value into a signed 32-bit word: wrap, or clamp when saturating.
    function automatic longint fit(input longint v, inout bit ov);
        longint w;
`ifdef EXP_SAT_EN
        if (v > 64'sd2147483647) begin
            ov = 1'b1;
            return 64'sd2147483647;
        end
        if (v < -64'sd2147483648) begin
            ov = 1'b1;
            return -64'sd2147483648;
        end
        w = v;
`else
        w = v & 64'h0000_0000_FFFF_FFFF;
        if (w >= 64'sh0000_0000_8000_0000) w = w - 64'sh0000_0001_0000_0000;
`endif
        return w;
    endfunction

    function automatic void model(input logic [31:0] xv, input bit neg, input int nt,
                                  output logic [31:0] yv, output bit ov);
        longint s, acc, t;
        ov  = 1'b0;
        s   = longint'($signed(xv));
        if (neg) s = fit(-s, ov);
        acc = ONE_L;
        for (int k = nt - 1; k >= 1; k--) begin
            t   = fit((s * acc) >>> F, ov);
            t   = fit((t * inv_of(k)) >>> F, ov);
            acc = fit(ONE_L + t, ov);
        end
`ifdef EXP_SAT_EN
        if (acc < 0) begin
            acc = 0;
            ov  = 1'b1;
        end
`endif
        yv = acc[31:0];
    endfunction

    // Drives one transaction on the 8-term instance and returns what it saw.
    task automatic drive_txn(input logic [31:0] xv, input bit neg,
                             output logic [31:0] yv, output bit ov, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        x        = xv;
        neg_mode = neg;
        @(negedge clk);
        in_valid = 1'b0;
        x        = $urandom;
        neg_mode = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        yv = y;
        ov = ovf;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b1;
        #1;
        n_tests++;
        if (y !== 32'h0 || out_valid !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: y=%h out_valid=%b ovf=%b, need 0/0/0", y, out_valid, ovf);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, need 1", in_ready);
        end
    endtask

    task automatic test_known_vectors;
        logic [31:0] xs[5]   = '{32'h0, 32'h0001_0000, 32'h0001_0000, 32'h0000_8000, 32'h0014_0000};
        bit          ns[5]   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ref_c[5] = '{32'h0001_0000, 32'h0000_5E2D, 32'h0002_B7E1, 32'h0000_9B45, 32'h0};
        int          tol[5]  = '{0, 4, 8, 4, -1};
        logic [31:0] yv, ym;
        bit          ov, om;
        int          lat, d;
        for (int i = 0; i < 5; i++) begin
            drive_txn(xs[i], ns[i], yv, ov, lat);
            model(xs[i], ns[i], 8, ym, om);
            n_tests++;
            if (lat !== 7) begin
                n_fail++;
                $display("FAIL known_latency[%0d]: got %0d cycles, need 7", i, lat);
            end
            n_tests++;
            if (yv !== ym || ov !== om) begin
                n_fail++;
                $display("FAIL known_value[%0d]: y=%h ovf=%b, need y=%h ovf=%b", i, yv, ov, ym, om);
            end
            if (tol[i] >= 0) begin
                d = int'(yv) - int'(ref_c[i]);
                n_tests++;
                if (d < -tol[i] || d > tol[i]) begin
                    n_fail++;
                    $display("FAIL known_accuracy[%0d]: y=%h, need %h +/- %0d", i, yv, ref_c[i],
                             tol[i]);
                end
            end
        end
`ifdef EXP_SAT_EN
        n_tests++;
        drive_txn(32'h0014_0000, 1'b0, yv, ov, lat);
        if (yv !== 32'h7FFF_FFFF || ov !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_e20: y=%h ovf=%b, need 7fffffff/1", yv, ov);
        end
`endif
    endtask

    task automatic test_random;
        logic [31:0] xv, yv, ym;
        bit          neg, ov, om;
        int          lat;
        for (int i = 0; i < 30; i++) begin
            if (i < 20) begin
                xv = 32'($urandom_range(0, 32'h0004_0000));
                if ($urandom_range(0, 1) == 1) xv = -xv;
            end else if (i == 20) begin
                xv = 32'h8000_0000;
            end else begin
                xv = $urandom;
            end
            neg = (i == 20) ? 1'b1 : 1'($urandom);
            drive_txn(xv, neg, yv, ov, lat);
            model(xv, neg, 8, ym, om);
            n_tests++;
            if (lat !== 7 || yv !== ym || ov !== om) begin
                n_fail++;
                $display("FAIL random[%0d] x=%h neg=%b: y=%h ovf=%b lat=%0d, need y=%h ovf=%b lat=7",
                         i, xv, neg, yv, ov, lat, ym, om);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] y0, ym;
        bit          om;
        int          lat;
        model(32'h0000_8000, 1'b1, 8, ym, om);
        @(negedge clk);
        in_valid = 1'b1;
        x        = 32'h0000_8000;
        neg_mode = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        y0 = y;
        n_tests++;
        if (lat !== 7 || y0 !== ym) begin
            n_fail++;
            $display("FAIL bp_result: y=%h lat=%0d, need y=%h lat=7", y0, lat, ym);
        end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'($urandom);
            x        = $urandom;
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || y !== y0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: out_valid=%b y=%h in_ready=%b, need 1/%h/0",
                         c, out_valid, y, in_ready, y0);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, need 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back;
        int          hits[$];
        int          want[3] = '{7, 16, 25};
        logic [31:0] ym;
        bit          om;
        model(32'h0001_0000, 1'b0, 8, ym, om);
        @(negedge clk);
        in_valid  = 1'b1;
        x         = 32'h0001_0000;
        neg_mode  = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 28; j++) begin
            @(negedge clk);
            if (out_valid) begin
                hits.push_back(j);
                n_tests++;
                if (y !== ym) begin
                    n_fail++;
                    $display("FAIL b2b_value at %0d: y=%h, need %h", j, y, ym);
                end
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (hits.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_pulse_count: got %0d, need 3", hits.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (hits[k] != want[k]) begin
                    n_fail++;
                    $display("FAIL b2b_pulse_time[%0d]: got %0d, need %0d", k, hits[k], want[k]);
                end
            end
        end
        repeat (10) @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [31:0] yv;
        bit          ov;
        int          lat;
        // Leave a nonzero y behind, then reset in the middle of the iterations.
        drive_txn(32'h0001_0000, 1'b1, yv, ov, lat);
        @(negedge clk);
        in_valid = 1'b1;
        x        = 32'h0001_0000;
        neg_mode = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || y !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_iter: out_valid=%b y=%h, need 0/0", out_valid, y);
        end
        @(negedge clk);
        reset = 1'b0;
        drive_txn(32'h0, 1'b0, yv, ov, lat);
        n_tests++;
        if (yv !== 32'h0001_0000 || lat !== 7) begin
            n_fail++;
            $display("FAIL reset_recover: y=%h lat=%0d, need 00010000/7", yv, lat);
        end
        // Reset while a result is still waiting for a consumer.
        @(negedge clk);
        in_valid = 1'b1;
        x        = 32'h0000_8000;
        neg_mode = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || y !== 32'h0 || lat !== 7) begin
            n_fail++;
            $display("FAIL reset_mid_done: out_valid=%b y=%h lat=%0d, need 0/0/7",
                     out_valid, y, lat);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_two_terms;
        logic [31:0] xs[2] = '{32'h0001_0000, 32'h0};
        logic [31:0] ym;
        bit          om;
        int          lat;
        xs[1] = 32'($urandom_range(0, 32'h0003_0000));
        for (int i = 0; i < 2; i++) begin
            model(xs[i], 1'b0, 2, ym, om);
            @(negedge clk);
            in_valid2 = 1'b1;
            x2        = xs[i];
            neg_mode2 = 1'b0;
            @(negedge clk);
            in_valid2 = 1'b0;
            lat = 0;
            while (!out_valid2 && lat < 50) begin
                @(negedge clk);
                lat++;
            end
            n_tests++;
            if (lat !== 1 || y2 !== ym || (i == 0 && y2 !== 32'h0002_0000)) begin
                n_fail++;
                $display("FAIL two_terms[%0d] x=%h: y=%h lat=%0d, need y=%h lat=1",
                         i, xs[i], y2, lat, ym);
            end
            out_ready2 = 1'b1;
            @(negedge clk);
            out_ready2 = 1'b0;
        end
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        x          = '0;
        neg_mode   = 1'b0;
        out_ready  = 1'b0;
        in_valid2  = 1'b0;
        x2         = '0;
        neg_mode2  = 1'b0;
        out_ready2 = 1'b0;
        test_reset();
        test_known_vectors();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_two_terms();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
